// File: rtl/tcp_slow_path_send_q.sv
// Shared payload types for the slow-path send queue.
package tcp_slow_path_send_q_pkg;

    localparam int unsigned FLOWID_W  = 16;
    localparam int unsigned IP_ADDR_W = 32;

    // TCP header fields carried to the TX header path.
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_pkt_hdr;

    // One queue entry: header plus addressing.
    typedef struct packed {
        tcp_pkt_hdr             pkt;
        logic [FLOWID_W-1:0]    flowid;
        logic [IP_ADDR_W-1:0]   src_ip;
        logic [IP_ADDR_W-1:0]   dst_ip;
    } sq_entry_t;

endpackage

// tcp_slow_path_send_q
// First-word-fall-through queue of slow-path TCP headers (e.g. SYN|ACK)
// handed from the rx datapath to the TX header path.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enq_val/enq_rdy     enqueue handshake; enq_* data fields
//   deq_val/deq_rdy     dequeue handshake; deq_* head fields (zero when empty)
//   occupancy           number of valid entries
//   drop_cnt            saturating count of enqueues refused while full
module tcp_slow_path_send_q
    import tcp_slow_path_send_q_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_val,
    input  tcp_pkt_hdr                 enq_pkt,
    input  logic [FLOWID_W-1:0]        enq_flowid,
    input  logic [IP_ADDR_W-1:0]       enq_src_ip,
    input  logic [IP_ADDR_W-1:0]       enq_dst_ip,
    output logic                       enq_rdy,
    output logic                       deq_val,
    output tcp_pkt_hdr                 deq_pkt,
    output logic [FLOWID_W-1:0]        deq_flowid,
    output logic [IP_ADDR_W-1:0]       deq_src_ip,
    output logic [IP_ADDR_W-1:0]       deq_dst_ip,
    input  logic                       deq_rdy,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [DROP_CNT_W-1:0]      drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tcp_slow_path_send_q: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         occ_q;
    logic [DROP_CNT_W-1:0] drop_q;
    sq_entry_t             mem [DEPTH];

    logic      full;
    logic      empty;
    logic      enq_fire;
    logic      deq_fire;
    logic      drop;
    sq_entry_t head;
    sq_entry_t wr_entry;

    // Wrap bit distinguishes full from empty when index bits match.
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    assign enq_rdy  = ~full;
    assign deq_val  = ~empty;
    assign enq_fire = enq_val & ~full;
    assign deq_fire = deq_rdy & ~empty;
    assign drop     = enq_val & full;

    assign wr_entry = '{pkt: enq_pkt, flowid: enq_flowid,
                        src_ip: enq_src_ip, dst_ip: enq_dst_ip};

    // Head presentation; gating hides stale storage when empty.
    assign head       = mem[rptr[AW-1:0]];
    assign deq_pkt    = deq_val ? head.pkt    : '0;
    assign deq_flowid = deq_val ? head.flowid : '0;
    assign deq_src_ip = deq_val ? head.src_ip : '0;
    assign deq_dst_ip = deq_val ? head.dst_ip : '0;

    assign occupancy = occ_q;
    assign drop_cnt  = drop_q;

    // Pointers, occupancy and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            occ_q  <= '0;
            drop_q <= '0;
        end else begin
            if (enq_fire) begin
                wptr <= wptr + PW'(1);
            end
            if (deq_fire) begin
                rptr <= rptr + PW'(1);
            end
            if (enq_fire && !deq_fire) begin
                occ_q <= occ_q + PW'(1);
            end else if (deq_fire && !enq_fire) begin
                occ_q <= occ_q - PW'(1);
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_CNT_W'(1);
            end
        end
    end

    // Entry storage, deliberately unreset.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wptr[AW-1:0]] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_tcp_slow_path_send_q.sv
// Self-checking bench for tcp_slow_path_send_q (DEPTH=8, DROP_CNT_W=4).
module tb_tcp_slow_path_send_q;
    import tcp_slow_path_send_q_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DCW    = 4;
    localparam int          DROP_MAX = 15;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     enq_val = 1'b0;
    tcp_pkt_hdr               enq_pkt = '0;
    logic [FLOWID_W-1:0]      enq_flowid = '0;
    logic [IP_ADDR_W-1:0]     enq_src_ip = '0;
    logic [IP_ADDR_W-1:0]     enq_dst_ip = '0;
    logic                     enq_rdy;
    logic                     deq_val;
    tcp_pkt_hdr               deq_pkt;
    logic [FLOWID_W-1:0]      deq_flowid;
    logic [IP_ADDR_W-1:0]     deq_src_ip;
    logic [IP_ADDR_W-1:0]     deq_dst_ip;
    logic                     deq_rdy = 1'b0;
    logic [$clog2(DEPTH):0]   occupancy;
    logic [DCW-1:0]           drop_cnt;

    tcp_slow_path_send_q #(.DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq_val    (enq_val),
        .enq_pkt    (enq_pkt),
        .enq_flowid (enq_flowid),
        .enq_src_ip (enq_src_ip),
        .enq_dst_ip (enq_dst_ip),
        .enq_rdy    (enq_rdy),
        .deq_val    (deq_val),
        .deq_pkt    (deq_pkt),
        .deq_flowid (deq_flowid),
        .deq_src_ip (deq_src_ip),
        .deq_dst_ip (deq_dst_ip),
        .deq_rdy    (deq_rdy),
        .occupancy  (occupancy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        tcp_pkt_hdr           pkt;
        logic [FLOWID_W-1:0]  flowid;
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
    } m_entry_t;

    m_entry_t mq[$];
    int       m_drops = 0;
    int       checks  = 0;
    int       errors  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue plus a saturating drop count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_drops = 0;
        end else begin
            automatic bit can_enq = (mq.size() != DEPTH);
            automatic bit can_deq = (mq.size() != 0);
            automatic m_entry_t e;
            e.pkt = enq_pkt; e.flowid = enq_flowid;
            e.src_ip = enq_src_ip; e.dst_ip = enq_dst_ip;
            if (deq_rdy && can_deq) void'(mq.pop_front());
            if (enq_val && can_enq) mq.push_back(e);
            else if (enq_val && m_drops < DROP_MAX) m_drops++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        automatic m_entry_t h;
        automatic bit has = (mq.size() != 0);
        if (has) h = mq[0];
        else begin
            h.pkt = '0; h.flowid = '0; h.src_ip = '0; h.dst_ip = '0;
        end
        chk("deq_val",    128'(deq_val),    128'(has));
        chk("enq_rdy",    128'(enq_rdy),    128'(mq.size() != DEPTH));
        chk("occupancy",  128'(occupancy),  128'(mq.size()));
        chk("drop_cnt",   128'(drop_cnt),   128'(m_drops));
        chk("deq_pkt",    128'(deq_pkt),    128'(h.pkt));
        chk("deq_flowid", 128'(deq_flowid), 128'(h.flowid));
        chk("deq_src_ip", 128'(deq_src_ip), 128'(h.src_ip));
        chk("deq_dst_ip", 128'(deq_dst_ip), 128'(h.dst_ip));
    end

    task automatic drive(input logic ev, input int fid, input logic [31:0] seq, input logic dr);
        enq_val           = ev;
        enq_flowid        = FLOWID_W'(fid);
        enq_pkt.src_port  = 16'(fid + 1000);
        enq_pkt.dst_port  = 16'd80;
        enq_pkt.seq_num   = seq;
        enq_pkt.ack_num   = ~seq;
        enq_pkt.flags     = 8'h12;
        enq_pkt.window    = 16'(fid * 3);
        enq_src_ip        = 32'hC0A8_0000 | 32'(fid);
        enq_dst_ip        = 32'h0A00_0000 + 32'(fid);
        deq_rdy           = dr;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        drive(1'b0, 0, 32'h0, 1'b0);
        #1;
        chk("rst_deq_val", 128'(deq_val), 128'(0));
        chk("rst_enq_rdy", 128'(enq_rdy), 128'(1));
        chk("rst_occ",     128'(occupancy), 128'(0));
        tick();
        rst_n = 1'b1;

        // Single pass
        drive(1'b1, 3, 32'hff, 1'b0);
        tick();
        chk("sp_deq_val", 128'(deq_val), 128'(1));
        chk("sp_flowid",  128'(deq_flowid), 128'(3));
        chk("sp_seq",     128'(deq_pkt.seq_num), 128'(32'hff));
        chk("sp_flags",   128'(deq_pkt.flags), 128'(8'h12));
        chk("sp_occ",     128'(occupancy), 128'(1));
        drive(1'b0, 77, 32'h1234, 1'b1);
        tick();
        chk("sp_empty_val",  128'(deq_val), 128'(0));
        chk("sp_empty_fid",  128'(deq_flowid), 128'(0));
        chk("sp_empty_pkt",  128'(deq_pkt), 128'(0));

        // Fill and overflow
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i, 32'(i * 16), 1'b0);
            tick();
            if (i == 7) begin
                chk("fill_occ8", 128'(occupancy), 128'(8));
                chk("fill_rdy0", 128'(enq_rdy), 128'(0));
            end
        end
        chk("fill_drops", 128'(drop_cnt), 128'(2));
        drive(1'b0, 0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 128'(deq_flowid), 128'(i));
            tick();
        end
        chk("drain_empty", 128'(deq_val), 128'(0));

        // Wrap-around at occupancy 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 100 + i, 32'(i), 1'b0);
            tick();
        end
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 103 + i, 32'(i + 3), 1'b1);
            chk("wrap_order", 128'(deq_flowid), 128'(100 + i));
            tick();
            chk("wrap_occ", 128'(occupancy), 128'(3));
        end

        // Full plus simultaneous dequeue
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 20 + i, 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 99, 32'h99, 1'b1);
        tick();
        chk("fd_occ7",  128'(occupancy), 128'(7));
        chk("fd_drop1", 128'(drop_cnt), 128'(1));
        chk("fd_head",  128'(deq_flowid), 128'(21));
        drive(1'b1, 50, 32'h50, 1'b0);
        tick();
        chk("fd_occ8",  128'(occupancy), 128'(8));
        chk("fd_drop_hold", 128'(drop_cnt), 128'(1));

        // Saturation: 20 more drops into the full queue
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 200 + i, 32'(i), 1'b0);
            tick();
        end
        chk("sat_15", 128'(drop_cnt), 128'(15));
        tick();
        chk("sat_hold", 128'(drop_cnt), 128'(15));

        // Dequeue three (order 21,22,23) to reach occupancy 5
        drive(1'b0, 0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_occ", 128'(occupancy), 128'(5));
        chk("pre_rst_head", 128'(deq_flowid), 128'(24));

        // Asynchronous reset mid-cycle
        drive(1'b0, 0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_deq_val", 128'(deq_val), 128'(0));
        chk("arst_occ",     128'(occupancy), 128'(0));
        chk("arst_drop",    128'(drop_cnt), 128'(0));
        chk("arst_enq_rdy", 128'(enq_rdy), 128'(1));
        chk("arst_data",    128'(deq_flowid), 128'(0));
        tick();
        rst_n = 1'b1;
        drive(1'b1, 9, 32'h9, 1'b0);
        tick();
        chk("post_rst_enq", 128'(occupancy), 128'(1));
        chk("post_rst_fid", 128'(deq_flowid), 128'(9));
        drive(1'b0, 0, 32'h0, 1'b1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

endmodule

// File: doc/tcp_slow_path_send_q.md
TCP_SLOW_PATH_SEND_Q -- requirements
Module: tcp_slow_path_send_q

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving queue entries; it must be a power of two and at least 2.
REQ-002 The block SHALL have parameter DROP_CNT_W, default 16, giving the width of the drop counter.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enq_val  in  1  enqueue request; driven by the rx datapath slow-path send stage
- enq_pkt  in  tcp_pkt_hdr  TCP header to send (SYN|ACK from the rx datapath)
- enq_flowid  in  FLOWID_W  flow ID
- enq_src_ip  in  IP_ADDR_W  source IP for the outbound packet
- enq_dst_ip  in  IP_ADDR_W  destination IP for the outbound packet
- enq_rdy  out  1  space available
- deq_val  out  1  head entry valid
- deq_pkt  out  tcp_pkt_hdr  head header
- deq_flowid  out  FLOWID_W  head flow ID
- deq_src_ip  out  IP_ADDR_W  head source IP
- deq_dst_ip  out  IP_ADDR_W  head destination IP
- deq_rdy  in  1  consumer (TX header path) accepts the head
- occupancy  out  $clog2(DEPTH)+1  number of valid entries
- drop_cnt  out  DROP_CNT_W  count of dropped enqueues, saturating

Function
REQ-005 An enqueue SHALL fire on a rising edge when enq_val=1 and enq_rdy=1; a dequeue SHALL fire when deq_val=1 and deq_rdy=1.
REQ-006 enq_rdy SHALL equal (occupancy != DEPTH), derived from registered state only, with no combinational path from deq_rdy.
REQ-007 deq_val SHALL equal (occupancy != 0), derived from registered state only.
REQ-008 The queue SHALL be first-word-fall-through: an entry enqueued at edge N SHALL be presented with deq_val=1 in cycle N+1 if it is the head.
REQ-009 When deq_val=0, deq_pkt, deq_flowid, deq_src_ip and deq_dst_ip SHALL be driven to all-zero.
REQ-010 Read and write pointers SHALL be $clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit; full is defined as equal index bits with differing MSB, and empty as pointers fully equal.
REQ-011 Pointers SHALL increment modulo 2*DEPTH; wrap from index DEPTH-1 back to 0 SHALL preserve FIFO order.
REQ-012 Occupancy SHALL be updated as follows:
- enqueue only: +1
- dequeue only: -1
- both: unchanged
- neither: unchanged
REQ-013 A simultaneous enqueue and dequeue SHALL be legal at any non-full, non-empty occupancy.
REQ-014 When empty, the block SHALL perform only the enqueue (no bypass: the entry is not visible in the same cycle).
REQ-015 When full, enq_rdy=0, so a simultaneous dequeue frees a slot that becomes usable only in the next cycle.
REQ-016 An enqueue attempt with enq_val=1 and enq_rdy=0 SHALL be a drop: no storage write, no pointer change, and drop_cnt incremented by 1, saturating at all-ones.
REQ-017 Head outputs SHALL remain stable while deq_val=1 and deq_rdy=0.
REQ-018 Entry storage SHALL be written only on enqueue, capturing all four enq_* data fields of that cycle as one entry.
REQ-019 enq_* data inputs SHALL be ignored when enq_val=0.
REQ-020 deq_rdy SHALL be ignored when deq_val=0; a dequeue on empty SHALL have no effect and SHALL NOT cause underflow.

Reset
REQ-021 On rst_n=0, independent of clk, the following SHALL be cleared: read/write pointers to 0, occupancy to 0, and drop_cnt to 0.
REQ-022 The resulting outputs during and after reset SHALL be: deq_val=0, enq_rdy=1, and deq data zero.
REQ-023 Entry storage SHALL NOT be reset, and stale contents SHALL never be observable.
REQ-024 Reset asserted mid-operation SHALL discard all queued entries, and no dequeue SHALL fire in the reset cycle.
REQ-025 After rst_n deasserts, the first enqueue SHALL be accepted on the first rising edge.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Single pass: enqueue flowid=3, seq_num=32'hff, flags SYN|ACK, with deq_rdy=0 -> next cycle deq_val=1, deq_flowid=3, occupancy=1; assert deq_rdy -> following cycle deq_val=0, outputs zero.
- Fill/overflow (DEPTH=8): 10 back-to-back enqueues of flowids 0..9 with deq_rdy=0 -> occupancy=8, enq_rdy=0 after the 8th, drop_cnt=2; drain -> flowids 0..7 in order.
- Wrap-around: 13 enqueue/dequeue pairs at occupancy 3 -> order preserved across index 7->0, occupancy stays 3.
- Full + dequeue: at occupancy=8, enq_val=1 and deq_rdy=1 in the same cycle -> dequeue fires, enqueue counts as a drop, occupancy=7; enqueue next cycle is accepted.
- Saturation: with DROP_CNT_W=4, 20 enqueues into a full queue -> drop_cnt=15 and holds.
- Async reset: assert rst_n=0 mid-cycle with occupancy=5 -> deq_val=0, occupancy=0 and drop_cnt=0 immediately, without a clock edge.
